// File: rtl/geofence_feeder_if.sv
// rtl/geofence_feeder_if.sv - point-memory, receiver and result-buffer signals of the geofence feeder
interface geofence_feeder_if #(
  parameter int ADDR_W = 7
) ();
  logic              start;
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [9:0]        mem_x;
  logic [9:0]        mem_y;
  logic [9:0]        X;
  logic [9:0]        Y;
  logic              send;
  logic              valid;
  logic              is_inside;
  logic              res_we;
  logic [3:0]        res_addr;
  logic              res_data;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    input  start, mem_x, mem_y, valid, is_inside,
    output mem_rd, mem_addr, X, Y, send, res_we, res_addr, res_data, busy, done, err
  );

  modport slave (
    output start, mem_x, mem_y, valid, is_inside,
    input  mem_rd, mem_addr, X, Y, send, res_we, res_addr, res_data, busy, done, err
  );
endinterface

// File: rtl/geofence_feeder.sv
// rtl/geofence_feeder.sv - streams 7-point sets from point memory to the geofence receiver and logs results
module geofence_feeder #(
  parameter int NUM_SETS = 4,
  parameter int ADDR_W   = 7,
  parameter int TIMEOUT  = 63
) (
  input  logic             clk,
  input  logic             reset,
  geofence_feeder_if.master bus
);

  typedef enum logic [2:0] {S_IDLE, S_PRIME, S_SEND, S_WAIT, S_DONE} state_t;

  localparam logic [3:0] LAST_SET = 4'(NUM_SETS - 1);
  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [3:0]        set_q, set_d;
  logic [2:0]        k_q, k_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              res_we_q, res_we_d;
  logic [3:0]        res_addr_q, res_addr_d;
  logic              res_data_q, res_data_d;
  logic              rd;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      set_q      <= '0;
      k_q        <= '0;
      ptr_q      <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      res_we_q   <= 1'b0;
      res_addr_q <= '0;
      res_data_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      set_q      <= set_d;
      k_q        <= k_d;
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      res_we_q   <= res_we_d;
      res_addr_q <= res_addr_d;
      res_data_q <= res_data_d;
    end
  end

  // ptr_q always holds the address presented on mem_addr when rd is high
  always_comb begin
    state_d    = state_q;
    set_d      = set_q;
    k_d        = k_q;
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    res_we_d   = 1'b0;
    res_addr_d = res_addr_q;
    res_data_d = res_data_q;
    rd         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_PRIME;
          set_d   = '0;
          k_d     = '0;
          ptr_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_PRIME: begin
        rd      = 1'b1;
        ptr_d   = ptr_q + ADDR_W'(1);
        k_d     = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (k_q != 3'd6) begin
          rd    = 1'b1;
          ptr_d = ptr_q + ADDR_W'(1);
          k_d   = k_q + 3'd1;
        end else begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Prefetch next set's point 0 so its burst can follow valid with no PRIME
        rd = (set_q != LAST_SET);
        if (bus.valid || (cnt_q == TO_LAST)) begin
          res_we_d   = 1'b1;
          res_addr_d = set_q;
          res_data_d = bus.valid & bus.is_inside;
          if (!bus.valid) begin
            err_d = 1'b1;
          end
          if (set_q == LAST_SET) begin
            state_d = S_DONE;
          end else begin
            set_d   = set_q + 4'd1;
            k_d     = '0;
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = S_SEND;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.mem_rd   = rd;
  assign bus.mem_addr = rd ? ptr_q : '0;
  assign bus.send     = (state_q == S_SEND);
  assign bus.X        = bus.send ? bus.mem_x : 10'd0;
  assign bus.Y        = bus.send ? bus.mem_y : 10'd0;
  assign bus.busy     = (state_q == S_PRIME) || (state_q == S_SEND) || (state_q == S_WAIT);
  assign bus.done     = (state_q == S_DONE);
  assign bus.err      = err_q;
  assign bus.res_we   = res_we_q;
  assign bus.res_addr = res_addr_q;
  assign bus.res_data = res_data_q;

endmodule

// File: tb/tb_geofence_feeder.sv
// tb/tb_geofence_feeder.sv - directed self-checking bench for geofence_feeder (3 sets, timeout 8)
module tb_geofence_feeder;

  localparam int NS = 3;

  logic clk = 1'b0;
  logic reset;
  int   n_total = 0;
  int   n_pass  = 0;

  int tx [7] = '{5, 0, 10, 10, 0, 0, 5};
  int ty [7] = '{5, 0, 0, 10, 10, 5, 10};
  logic [9:0] mx [128];
  logic [9:0] my [128];

  geofence_feeder_if #(.ADDR_W(7)) bus ();

  geofence_feeder #(.NUM_SETS(NS), .ADDR_W(7), .TIMEOUT(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  function automatic int xv(input int a);
    return (a < 7) ? tx[a] : ((a * 13 + 7) % 1024);
  endfunction

  function automatic int yv(input int a);
    return (a < 7) ? ty[a] : (1000 - a);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_rd) begin
      bus.mem_x <= mx[bus.mem_addr];
      bus.mem_y <= my[bus.mem_addr];
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_flags"}, 32'({bus.mem_rd, bus.send, bus.res_we, bus.busy, bus.done, bus.err}), 0);
    chk({tag, "_addr"}, 32'(bus.mem_addr), 0);
    chk({tag, "_xy"}, 32'({bus.X, bus.Y}), 0);
    chk({tag, "_res"}, 32'({bus.res_addr, bus.res_data}), 0);
  endtask

  // Starts at the negedge of SEND k=0 of set s; ends at the negedge where its result write is visible
  task automatic do_set(input int s, input int nwait, input bit give_valid, input bit ans,
                        input bit stray, input int abort_k);
    for (int k = 0; k < 7; k++) begin
      chk("send", 32'(bus.send), 1);
      chk("x", 32'(bus.X), 32'(xv(s * 7 + k)));
      chk("y", 32'(bus.Y), 32'(yv(s * 7 + k)));
      chk("send_rd", 32'(bus.mem_rd), (k < 6) ? 1 : 0);
      if (k < 6) chk("send_addr", 32'(bus.mem_addr), 32'(s * 7 + k + 1));
      if (k > 0) chk("send_we", 32'(bus.res_we), 0);
      if (k == abort_k) return;
      bus.valid     = stray && (k == 3);
      bus.is_inside = stray && (k == 3);
      step();
    end
    for (int w = 1; w <= nwait; w++) begin
      chk("wait_send", 32'({bus.send, bus.X}), 0);
      chk("wait_rd", 32'(bus.mem_rd), (s < NS - 1) ? 1 : 0);
      chk("wait_addr", 32'(bus.mem_addr), (s < NS - 1) ? 32'((s + 1) * 7) : 0);
      chk("wait_we", 32'(bus.res_we), 0);
      chk("wait_busy", 32'(bus.busy), 1);
      bus.start     = (w == 2);
      bus.valid     = give_valid && (w == nwait);
      bus.is_inside = ans;
      step();
    end
    bus.start = 1'b0;
    bus.valid = 1'b0;
    chk("res_we", 32'(bus.res_we), 1);
    chk("res_addr", 32'(bus.res_addr), 32'(s));
    chk("res_data", 32'(bus.res_data), give_valid ? 32'(ans) : 0);
  endtask

  initial begin
    for (int a = 0; a < 128; a++) begin
      mx[a] = 10'(xv(a));
      my[a] = 10'(yv(a));
    end
    bus.mem_x     = '0;
    bus.mem_y     = '0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.valid     = 1'b0;
    bus.is_inside = 1'b0;
    step();
    step();
    chk_idle_outputs("reset");
    reset = 1'b1;
    step();

    // Run 1: answers 1,0,1; stray valid in set 0, start during WAIT, valid coincident with timeout on set 2
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("prime_busy", 32'(bus.busy), 1);
    chk("prime_rd", 32'(bus.mem_rd), 1);
    chk("prime_addr", 32'(bus.mem_addr), 0);
    chk("prime_send", 32'(bus.send), 0);
    step();
    do_set(0, 4, 1'b1, 1'b1, 1'b1, -1);
    do_set(1, 1, 1'b1, 1'b0, 1'b0, -1);
    do_set(2, 8, 1'b1, 1'b1, 1'b0, -1);
    chk("r1_done", 32'(bus.done), 1);
    chk("r1_busy", 32'(bus.busy), 0);
    chk("r1_err", 32'(bus.err), 0);
    step();
    chk("r1_idle", 32'({bus.done, bus.res_we, bus.busy}), 0);

    // Run 2: set 1 never answered -> timeout write of 0 and sticky err
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    do_set(0, 2, 1'b1, 1'b0, 1'b0, -1);
    do_set(1, 8, 1'b0, 1'b1, 1'b0, -1);
    chk("r2_err_set", 32'(bus.err), 1);
    do_set(2, 3, 1'b1, 1'b1, 1'b0, -1);
    chk("r2_done", 32'(bus.done), 1);
    chk("r2_err_done", 32'(bus.err), 1);
    step();
    chk("r2_err_idle", 32'(bus.err), 1);

    // Run 3: new start clears err; reset lands in SEND k=4 of set 2
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("r3_err_clr", 32'(bus.err), 0);
    chk("r3_prime_addr", 32'(bus.mem_addr), 0);
    step();
    do_set(0, 1, 1'b1, 1'b1, 1'b0, -1);
    do_set(1, 1, 1'b1, 1'b1, 1'b0, -1);
    do_set(2, 0, 1'b0, 1'b0, 1'b0, 4);
    reset = 1'b0;
    #1;
    chk_idle_outputs("async_rst");
    step();
    reset = 1'b1;
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("r4_prime_rd", 32'(bus.mem_rd), 1);
    chk("r4_prime_addr", 32'(bus.mem_addr), 0);
    step();
    chk("r4_send", 32'(bus.send), 1);
    chk("r4_x0", 32'(bus.X), 5);
    chk("r4_addr1", 32'(bus.mem_addr), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
